// File: rtl/smart_speaker_control.sv
// Voice-command controller: turns edge-qualified 2-bit commands into on/off
// states for four appliances held in a registered device_state vector.
module smart_speaker_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] voice_command,
  output logic [3:0] device_state
);

  localparam int unsigned NUM_DEV = 4;
  localparam int unsigned CMD_W   = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE     = 2'b00,
    CMD_ON_NEXT  = 2'b01,
    CMD_OFF_LAST = 2'b10,
    CMD_ALL_OFF  = 2'b11
  } cmd_e;

  cmd_e               cmd_q;
  cmd_e               prev_q;
  logic               exec_c;
  logic [NUM_DEV-1:0] on_next_c;
  logic [NUM_DEV-1:0] off_last_c;
  logic [NUM_DEV-1:0] state_next_c;

  // Command pipeline: current and previous sampled command.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= CMD_NONE;
      prev_q <= CMD_NONE;
    end else begin
      cmd_q  <= cmd_e'(voice_command);
      prev_q <= cmd_q;
    end
  end

  // A command acts only on the first cycle it appears in cmd_q.
  assign exec_c = (cmd_q != CMD_NONE) && (cmd_q != prev_q);

  // Candidate results: set lowest clear bit / clear highest set bit.
  always_comb begin
    on_next_c  = device_state;
    off_last_c = device_state;
    casez (device_state)
      4'b???0: on_next_c = device_state | 4'b0001;
      4'b??01: on_next_c = device_state | 4'b0010;
      4'b?011: on_next_c = device_state | 4'b0100;
      4'b0111: on_next_c = device_state | 4'b1000;
      default: on_next_c = device_state;
    endcase
    casez (device_state)
      4'b1???: off_last_c = device_state & 4'b0111;
      4'b01??: off_last_c = device_state & 4'b1011;
      4'b001?: off_last_c = device_state & 4'b1101;
      4'b0001: off_last_c = device_state & 4'b1110;
      default: off_last_c = device_state;
    endcase
  end

  // Next device state selected by the qualified command.
  always_comb begin
    state_next_c = device_state;
    if (exec_c) begin
      case (cmd_q)
        CMD_ON_NEXT:  state_next_c = on_next_c;
        CMD_OFF_LAST: state_next_c = off_last_c;
        CMD_ALL_OFF:  state_next_c = '0;
        default:      state_next_c = device_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      device_state <= '0;
    end else begin
      device_state <= state_next_c;
    end
  end

endmodule

// File: tb/tb_smart_speaker_control.sv
// Scoreboard bench for smart_speaker_control: a history-based reference model
// queues the expected device_state per edge; a monitor pops and compares.
module tb_smart_speaker_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] voice_command;
  logic [3:0] device_state;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];

  // Model history: inputs seen at the previous two edges.
  logic [3:0] model_state;
  logic [1:0] in1 = 2'b00, in2 = 2'b00;
  logic       r1 = 1'b1, r2 = 1'b1;

  smart_speaker_control dut (
    .clk          (clk),
    .rst          (rst),
    .voice_command(voice_command),
    .device_state (device_state)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] apply_cmd(input logic [3:0] s, input logic [1:0] c);
    logic [3:0] n;
    n = s;
    case (c)
      2'b01: begin
        for (int i = 0; i < 4; i++) begin
          if (!n[i]) begin
            n[i] = 1'b1;
            break;
          end
        end
      end
      2'b10: begin
        for (int i = 3; i >= 0; i--) begin
          if (n[i]) begin
            n[i] = 1'b0;
            break;
          end
        end
      end
      2'b11:   n = 4'b0000;
      default: n = s;
    endcase
    return n;
  endfunction

  // Drive one cycle's inputs and queue the state expected after that edge.
  // A command takes effect one edge after it is first seen, and only if it
  // differs from what was seen the edge before (reset clears that history).
  task automatic step(input logic r, input logic [1:0] c);
    logic [1:0] seen_now, seen_before;
    rst           = r;
    voice_command = c;
    seen_now    = r1 ? 2'b00 : in1;
    seen_before = (r1 || r2) ? 2'b00 : in2;
    if (r)
      model_state = 4'b0000;
    else if (seen_now != 2'b00 && seen_now != seen_before)
      model_state = apply_cmd(model_state, seen_now);
    exp_q.push_back(model_state);
    r2  = r1;
    in2 = in1;
    r1  = r;
    in1 = c;
    @(negedge clk);
  endtask

  task automatic hold(input logic [1:0] c, input int n);
    for (int k = 0; k < n; k++) step(1'b0, c);
  endtask

  // Monitor: device_state is sampled 1 time unit after every rising edge.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (device_state !== e) begin
          errors++;
          $display("FAIL device_state @%0t: got %b expected %b", $time, device_state, e);
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    voice_command = 2'b00;

    // Reset, then a single held ON.
    step(1'b1, 2'b00);
    hold(2'b00, 1);
    hold(2'b01, 5);
    hold(2'b00, 2);

    // Back-to-back ON then OFF.
    step(1'b0, 2'b01);
    step(1'b0, 2'b10);
    hold(2'b00, 3);

    // Five ON pulses with release: saturates at 1111.
    for (int p = 0; p < 5; p++) begin
      step(1'b0, 2'b01);
      step(1'b0, 2'b00);
    end
    hold(2'b00, 2);

    // OFF twice with release, then ON again.
    for (int p = 0; p < 2; p++) begin
      step(1'b0, 2'b10);
      step(1'b0, 2'b00);
    end
    step(1'b0, 2'b01);
    hold(2'b00, 2);

    // ALL_OFF, then OFF on an empty state.
    hold(2'b11, 3);
    step(1'b0, 2'b10);
    hold(2'b00, 3);

    // Build up to 0011, then reset while ON is held through release.
    step(1'b0, 2'b01);
    step(1'b0, 2'b00);
    step(1'b0, 2'b01);
    step(1'b0, 2'b00);
    hold(2'b01, 2);
    step(1'b1, 2'b01);
    hold(2'b01, 6);

    // Direct change between non-zero codes with no gap.
    hold(2'b00, 2);
    step(1'b0, 2'b01);
    step(1'b0, 2'b01);
    step(1'b0, 2'b11);
    step(1'b0, 2'b01);
    step(1'b0, 2'b10);
    hold(2'b00, 2);

    // Randomized commands with random hold lengths and occasional reset.
    for (int k = 0; k < 300; k++) begin
      logic [1:0] c;
      int         len;
      c   = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 3));
      if ($urandom_range(0, 40) == 0)
        step(1'b1, c);
      for (int j = 0; j < len; j++) step(1'b0, c);
    end
    hold(2'b00, 3);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
